trigger_ctrl: RTL and testbench
===============================

# trigger_ctrl

Parametrised trigger and capture controller for the oscilloscope acquisition path, between the ADC sample stream and the dual-clock capture FIFO. Detects threshold crossings with programmable level, hysteresis and edge polarity, then writes a programmable number of post-trigger samples into the FIFO. Supports normal, single-shot and auto (forced-trigger) modes, and re-arms only once the read side has drained the FIFO.

## Interface
Parameters:
- DATA_SIZE, 12, sample width in bits
- ADDR_SIZE, 8, FIFO address width; capture depth is 2^ADDR_SIZE samples
- AUTO_TIMEOUT, 1024, clk_i cycles in ARMED before auto mode forces a trigger

Ports:
- clk_i  in  1  sample-domain clock
- rst_i  in  1  reset, asynchronous, active-low
- sample_data_i  in  DATA_SIZE  ADC sample
- sample_valid_i  in  1  sample_data_i valid this cycle
- threshold_i  in  DATA_SIZE  trigger level, unsigned
- hysteresis_i  in  DATA_SIZE  hysteresis band below threshold
- edge_sel_i  in  2  00 rising, 01 falling, 10 either, 11 none
- mode_i  in  2  00 normal, 01 single, 10 auto, 11 treated as normal
- post_count_i  in  ADDR_SIZE+1  samples to capture per trigger
- arm_i  in  1  one-cycle arm request
- fifo_empty_i  in  1  FIFO empty flag, read clock domain (asynchronous)
- data_o  out  DATA_SIZE  registered sample to FIFO write port
- w_en_o  out  1  FIFO write enable, qualifies data_o
- trigger_o  out  1  one-cycle pulse, aligned with the triggering sample on data_o
- done_o  out  1  one-cycle pulse on the last written sample
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2

## Operation
- Level tracker `above`, updated only on sample_valid_i: set when sample >= threshold_i; cleared when sample < threshold_i - hysteresis_i; otherwise held. The subtraction saturates at 0, so `above` never clears when hysteresis_i >= threshold_i. Reset value 0.
- Edge events, computed combinationally from `above` and its next value on a valid sample: rise = 0->1, fall = 1->0. edge_sel_i selects the qualifying event; 11 never qualifies.
- fifo_empty_i passes through a 2-flop synchroniser (reset to 0). Result: empty_s.
- States:
  - IDLE: outputs quiet. arm_i -> ARMED.
  - ARMED: a qualifying event on a valid sample while empty_s=1 -> CAPTURE. The triggering sample is written with trigger_o=1. The remaining counter loads eff_count-1.
  - CAPTURE: each valid sample is written and decrements the counter. The write taken at counter 0 asserts done_o, then the next state is IDLE in single mode, otherwise ARMED.
- eff_count = post_count_i clamped to [1, 2^ADDR_SIZE]; 0 is treated as 1. It is latched at the trigger, so later changes to post_count_i do not affect the capture in progress.
- Auto mode: a timeout counter runs while in ARMED and empty_s=1, clears on leaving ARMED, and at AUTO_TIMEOUT forces a trigger on the next valid sample.
- arm_i is ignored outside IDLE.
- mode_i is sampled at trigger time and again at capture completion.
- threshold_i, hysteresis_i and edge_sel_i take effect on the next valid sample.

## Timing
- Reset values: data_o=0, w_en_o=0, trigger_o=0, done_o=0, state_o=IDLE. After reset the block requires arm_i before the first capture.
- Latency: a sample at cycle t appears on data_o/w_en_o at t+1. trigger_o and done_o coincide with the corresponding w_en_o.
- No write in cycles without sample_valid_i; gaps in valid stretch the capture.
- A qualifying event in the same cycle as arm_i is not taken, because the state must already be ARMED.
- empty_s=0 in ARMED blocks triggers, including forced triggers.
- fifo_empty_i is not checked during CAPTURE; overflow protection is the depth clamp.
- A single-sample capture (eff_count=1) asserts trigger_o and done_o in the same cycle.
- Reset mid-capture returns to IDLE immediately with w_en_o=0. The partial FIFO contents are the reader's concern.

## Configuration
- TRIG_AUTO_EN defined: the auto-mode timeout counter and forced trigger are compiled in.
- Not defined: the counter is absent; mode 10 behaves exactly as normal, and edge_sel_i=11 never captures.

## Test plan
- Normal, rising, threshold 0x800, hyst 0x010, post 4, ramp 0x7F0->0x810 step 8, FIFO empty -> trigger_o with data_o=0x800, 4 writes, done_o on the 4th, state_o returns to ARMED.
- Hysteresis: after trigger, samples oscillating 0x7F8/0x802 -> no second rise event. A dip to 0x7EF, then 0x800 -> new trigger.
- Single mode, falling, post 0 -> one write with trigger_o=done_o=1, state IDLE. Further crossings ignored until arm_i.
- fifo_empty_i=0 in ARMED with a crossing -> no write. Raise fifo_empty_i -> the first crossing at least 2 cycles later triggers.
- Auto, edge 11, AUTO_TIMEOUT=16, constant 0x100 -> forced trigger after 16 ARMED cycles, 4 writes. Without TRIG_AUTO_EN -> no writes ever.
- Reset asserted on the 2nd capture write -> w_en_o=0 asynchronously, state IDLE, arm_i required to resume.

Source files
------------

// File: rtl/trigger_ctrl.sv
// Threshold trigger and post-trigger capture controller feeding the acquisition FIFO.
// Optional macro TRIG_AUTO_EN compiles in the auto-mode timeout and forced trigger.
module trigger_ctrl #(
  parameter int DATA_SIZE    = 12,
  parameter int ADDR_SIZE    = 8,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_SIZE-1:0] sample_data_i,
  input  logic                 sample_valid_i,
  input  logic [DATA_SIZE-1:0] threshold_i,
  input  logic [DATA_SIZE-1:0] hysteresis_i,
  input  logic [1:0]           edge_sel_i,
  input  logic [1:0]           mode_i,
  input  logic [ADDR_SIZE:0]   post_count_i,
  input  logic                 arm_i,
  input  logic                 fifo_empty_i,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 w_en_o,
  output logic                 trigger_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   above_q, above_d;
  logic                   empty_meta_q, empty_s_q;
  logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   w_en_q, w_en_d;
  logic                   trigger_q, trigger_d;
  logic                   done_q, done_d;
  logic [DATA_SIZE-1:0]   lower_bound;
  logic [ADDR_SIZE:0]     post_m1;
  logic [ADDR_SIZE-1:0]   eff_m1;
  logic                   rise, fall, qualify, force_trig;
  state_t                 after_done;

  // Saturating lower edge of the hysteresis band; 0 means the tracker can never clear.
  always_comb begin
    lower_bound = (hysteresis_i >= threshold_i) ? '0 : threshold_i - hysteresis_i;
    above_d     = above_q;
    if (sample_valid_i) begin
      if (sample_data_i >= threshold_i)      above_d = 1'b1;
      else if (sample_data_i < lower_bound)  above_d = 1'b0;
    end
    rise = above_d & ~above_q;
    fall = ~above_d & above_q;
    case (edge_sel_i)
      2'b00:   qualify = rise;
      2'b01:   qualify = fall;
      2'b10:   qualify = rise | fall;
      default: qualify = 1'b0;
    endcase
  end

  // Remaining writes after the trigger sample: post_count clamped to [1, depth], minus one.
  always_comb begin
    post_m1 = post_count_i - 1'b1;
    if (post_count_i == '0)
      eff_m1 = '0;
    else if (post_count_i[ADDR_SIZE] && (post_count_i[ADDR_SIZE-1:0] != '0))
      eff_m1 = '1;
    else
      eff_m1 = post_m1[ADDR_SIZE-1:0];
  end

`ifdef TRIG_AUTO_EN
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != ARMED)
      tmo_d = '0;
    else if (empty_s_q && (tmo_q != TMO_W'(AUTO_TIMEOUT)))
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign force_trig = (mode_i == 2'b10) && (tmo_q == TMO_W'(AUTO_TIMEOUT));
`else
  assign force_trig = 1'b0;
`endif

  assign after_done = (mode_i == 2'b01) ? IDLE : ARMED;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    w_en_d    = 1'b0;
    trigger_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i) state_d = ARMED;
      end
      ARMED: begin
        if (sample_valid_i && empty_s_q && (qualify || force_trig)) begin
          w_en_d    = 1'b1;
          trigger_d = 1'b1;
          data_d    = sample_data_i;
          cnt_d     = eff_m1;
          if (eff_m1 == '0) begin
            done_d  = 1'b1;
            state_d = after_done;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (sample_valid_i) begin
          w_en_d = 1'b1;
          data_d = sample_data_i;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == ADDR_SIZE'(1)) begin
            done_d  = 1'b1;
            state_d = after_done;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      above_q      <= 1'b0;
      empty_meta_q <= 1'b0;
      empty_s_q    <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
      w_en_q       <= 1'b0;
      trigger_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      above_q      <= above_d;
      empty_meta_q <= fifo_empty_i;
      empty_s_q    <= empty_meta_q;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      w_en_q       <= w_en_d;
      trigger_q    <= trigger_d;
      done_q       <= done_d;
    end
  end

  assign data_o    = data_q;
  assign w_en_o    = w_en_q;
  assign trigger_o = trigger_q;
  assign done_o    = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed table-driven bench for trigger_ctrl plus hand-written reset and depth-clamp sequences.
module tb_trigger_ctrl;

  localparam int DW = 12;
  localparam int AW = 3;
`ifdef TRIG_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] sample_data_i;
  logic          sample_valid_i;
  logic [DW-1:0] threshold_i;
  logic [DW-1:0] hysteresis_i;
  logic [1:0]    edge_sel_i;
  logic [1:0]    mode_i;
  logic [AW:0]   post_count_i;
  logic          arm_i;
  logic          fifo_empty_i;
  logic [DW-1:0] data_o;
  logic          w_en_o;
  logic          trigger_o;
  logic          done_o;
  logic [1:0]    state_o;

  trigger_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AUTO_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i),
    .threshold_i(threshold_i), .hysteresis_i(hysteresis_i),
    .edge_sel_i(edge_sel_i), .mode_i(mode_i), .post_count_i(post_count_i),
    .arm_i(arm_i), .fifo_empty_i(fifo_empty_i),
    .data_o(data_o), .w_en_o(w_en_o), .trigger_o(trigger_o),
    .done_o(done_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          v;
    logic [DW-1:0] smp;
    logic          arm;
    logic          emp;
    logic [1:0]    edge_sel;
    logic [1:0]    mode;
    logic [AW:0]   post;
    logic          wen;
    logic          trig;
    logic          done;
    logic [1:0]    state;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vec_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic row(input logic v, input logic [DW-1:0] smp, input logic arm, input logic emp,
                     input logic [1:0] e, input logic [1:0] m, input logic [AW:0] p,
                     input logic wen, input logic trig, input logic done,
                     input logic [1:0] st, input logic [DW-1:0] data);
    vec_t r;
    r.v = v; r.smp = smp; r.arm = arm; r.emp = emp; r.edge_sel = e; r.mode = m; r.post = p;
    r.wen = wen; r.trig = trig; r.done = done; r.state = st; r.data = data;
    vec_q.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] smp, input logic arm,
                       input logic [1:0] e, input logic [1:0] m, input logic [AW:0] p);
    sample_valid_i = v;
    sample_data_i  = smp;
    arm_i          = arm;
    edge_sel_i     = e;
    mode_i         = m;
    post_count_i   = p;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int writes;
    int done_at;

    // Normal mode, rising edge, post 4
    row(0, 12'h000, 1, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h7F0, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h7F8, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h800, 0, 1, 2'b00, 2'b00, 4'd4, 1, 1, 0, 2'd2, 12'h800);
    row(1, 12'h808, 0, 1, 2'b00, 2'b00, 4'd4, 1, 0, 0, 2'd2, 12'h808);
    row(1, 12'h810, 0, 1, 2'b00, 2'b00, 4'd4, 1, 0, 0, 2'd2, 12'h810);
    row(0, 12'h810, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd2, 12'h000);
    row(1, 12'h811, 0, 1, 2'b00, 2'b00, 4'd4, 1, 0, 1, 2'd1, 12'h811);
    // Hysteresis: oscillation inside the band gives no new rise
    row(1, 12'h7F8, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h802, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h7F8, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h802, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h7EF, 0, 1, 2'b00, 2'b00, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h800, 0, 1, 2'b00, 2'b00, 4'd4, 1, 1, 0, 2'd2, 12'h800);
    // post_count changes mid-capture must not shorten it
    row(1, 12'h801, 0, 1, 2'b00, 2'b00, 4'd1, 1, 0, 0, 2'd2, 12'h801);
    row(1, 12'h802, 0, 1, 2'b00, 2'b00, 4'd1, 1, 0, 0, 2'd2, 12'h802);
    row(1, 12'h803, 0, 1, 2'b00, 2'b00, 4'd1, 1, 0, 1, 2'd1, 12'h803);
    // Single mode, falling edge, post 0
    row(1, 12'h700, 0, 1, 2'b01, 2'b01, 4'd0, 1, 1, 1, 2'd0, 12'h700);
    row(1, 12'h900, 0, 1, 2'b01, 2'b01, 4'd0, 0, 0, 0, 2'd0, 12'h000);
    row(1, 12'h700, 0, 1, 2'b01, 2'b01, 4'd0, 0, 0, 0, 2'd0, 12'h000);
    row(0, 12'h700, 1, 1, 2'b01, 2'b01, 4'd0, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h900, 0, 1, 2'b01, 2'b01, 4'd0, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h7FF, 0, 1, 2'b01, 2'b01, 4'd0, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h7EF, 0, 0, 2'b01, 2'b01, 4'd0, 1, 1, 1, 2'd0, 12'h7EF);
    // FIFO not empty blocks triggers; re-enable needs the synchroniser delay
    row(0, 12'h7EF, 1, 0, 2'b00, 2'b00, 4'd2, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h900, 0, 0, 2'b00, 2'b00, 4'd2, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h700, 0, 1, 2'b00, 2'b00, 4'd2, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h900, 0, 1, 2'b00, 2'b00, 4'd2, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h700, 0, 1, 2'b00, 2'b00, 4'd2, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h900, 0, 1, 2'b00, 2'b00, 4'd2, 1, 1, 0, 2'd2, 12'h900);
    row(1, 12'h901, 0, 1, 2'b00, 2'b00, 4'd2, 1, 0, 1, 2'd1, 12'h901);
    // Auto mode, edge none: forced trigger after 16 ARMED cycles only when compiled in
    for (int i = 0; i < 16; i++)
      row(1, 12'h100, 0, 1, 2'b11, 2'b10, 4'd4, 0, 0, 0, 2'd1, 12'h000);
    row(1, 12'h100, 0, 1, 2'b11, 2'b10, 4'd4, AUTO_EN, AUTO_EN, 0, AUTO_EN ? 2'd2 : 2'd1, 12'h100);
    row(1, 12'h100, 0, 1, 2'b11, 2'b10, 4'd4, AUTO_EN, 0, 0, AUTO_EN ? 2'd2 : 2'd1, 12'h100);
    row(1, 12'h100, 0, 1, 2'b11, 2'b10, 4'd4, AUTO_EN, 0, 0, AUTO_EN ? 2'd2 : 2'd1, 12'h100);
    row(1, 12'h100, 0, 1, 2'b11, 2'b10, 4'd4, AUTO_EN, 0, AUTO_EN, 2'd1, 12'h100);

    // Clock/reset
    rst_i        = 1'b0;
    threshold_i  = 12'h800;
    hysteresis_i = 12'h010;
    fifo_empty_i = 1'b1;
    drive(0, '0, 0, 2'b00, 2'b00, 4'd4);
    #1;
    check("reset_state", {30'd0, state_o}, 32'd0);
    check("reset_outputs", {16'd0, data_o, w_en_o, trigger_o, done_o, 1'b0}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vec_q[i]) begin
      fifo_empty_i = vec_q[i].emp;
      drive(vec_q[i].v, vec_q[i].smp, vec_q[i].arm, vec_q[i].edge_sel, vec_q[i].mode, vec_q[i].post);
      step();
      check($sformatf("vec%0d_wen_trig_done_state", i),
            {27'd0, w_en_o, trigger_o, done_o, state_o},
            {27'd0, vec_q[i].wen, vec_q[i].trig, vec_q[i].done, vec_q[i].state});
      if (vec_q[i].wen)
        check($sformatf("vec%0d_data", i), {20'd0, data_o}, {20'd0, vec_q[i].data});
    end

    // Asynchronous reset on the second capture write
    fifo_empty_i = 1'b1;
    drive(1, 12'h900, 0, 2'b00, 2'b00, 4'd4);
    step();
    check("rst_seq_first_write", {30'd0, w_en_o, trigger_o}, 32'd3);
    drive(1, 12'h901, 0, 2'b00, 2'b00, 4'd4);
    step();
    check("rst_seq_second_write", {31'd0, w_en_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("rst_async_wen", {31'd0, w_en_o}, 32'd0);
    check("rst_async_state", {30'd0, state_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 12'h100, 0, 2'b00, 2'b00, 4'd4);
    step();
    drive(1, 12'h900, 0, 2'b00, 2'b00, 4'd4);
    step();
    check("no_arm_no_write", {29'd0, w_en_o, state_o}, 32'd0);
    drive(1, 12'h100, 1, 2'b00, 2'b00, 4'd4);
    step();
    check("rearm_state", {30'd0, state_o}, 32'd1);

    // Depth clamp: post 15 on an 8-deep FIFO gives 8 writes; later post changes ignored
    drive(1, 12'h900, 0, 2'b00, 2'b00, 4'd15);
    step();
    check("clamp_trigger", {30'd0, w_en_o, trigger_o}, 32'd3);
    writes  = 1;
    done_at = 0;
    for (int i = 1; i < 12; i++) begin
      drive(1, DW'(12'h900 + i), 0, 2'b00, 2'b00, 4'd1);
      step();
      if (w_en_o) writes++;
      if (done_o) done_at = writes;
    end
    check("clamp_write_count", writes, 32'd8);
    check("clamp_done_position", done_at, 32'd8);
    check("clamp_end_state", {30'd0, state_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
